// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream -> little-endian 32-bit imem writes, core held until image is complete.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int ADDR_W     = 10,
  parameter int BASE_WADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_s_valid,
  input  logic [7:0]        i_s_data,
  output logic              o_s_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam logic [33:0]   DEPTH   = 34'd1 << ADDR_W;
  localparam logic [33:0]   BASE34  = 34'(BASE_WADDR);
  localparam logic [ADDR_W:0] ONE   = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t S_AFTER_DATA = S_CHK;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_lane;
  logic [23:0]         r_word;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_words;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]          r_csum;
`endif

  logic                w_xfer;
  logic                w_arm;
  logic                w_lane_last;
  logic [31:0]         w_word;
  logic                w_len_ok;
  logic                w_last_word;

  assign o_s_ready   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  assign o_busy      = o_s_ready;
  assign o_done      = (r_state == S_DONE);
  assign o_err       = (r_state == S_ERROR);
  assign o_core_hold = (r_state != S_DONE);
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_words_loaded = r_words;

  assign w_xfer      = i_s_valid && o_s_ready;
  assign w_arm       = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_lane_last = (r_lane == 2'd3);
  assign w_word      = {i_s_data, r_word};
  // Compared in 34 bits so a huge 32-bit length cannot wrap past the capacity check.
  assign w_len_ok    = (BASE34 + {2'b00, w_word}) <= DEPTH;
  assign w_last_word = (r_words + ONE) == r_len;

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_xfer && w_lane_last) begin
          if (w_word == 32'd0)  w_next = S_AFTER_DATA;
          else if (!w_len_ok)   w_next = S_ERROR;
          else                  w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_xfer && w_lane_last && w_last_word) w_next = S_AFTER_DATA;
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CHK: begin
        if (w_xfer) w_next = (i_s_data == r_csum) ? S_DONE : S_ERROR;
      end
`endif
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_lane      <= 2'd0;
      r_word      <= 24'd0;
      r_len       <= '0;
      r_words     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CSUM_EN
      r_csum      <= 8'd0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      if (w_arm) begin
        r_lane  <= 2'd0;
        r_words <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        r_csum  <= 8'd0;
`endif
      end else if (w_xfer && (r_state == S_LEN || r_state == S_DATA)) begin
        r_lane <= r_lane + 2'd1;
        case (r_lane)
          2'd0:    r_word[7:0]   <= i_s_data;
          2'd1:    r_word[15:8]  <= i_s_data;
          2'd2:    r_word[23:16] <= i_s_data;
          default: ;
        endcase
        if (r_state == S_LEN) begin
          if (w_lane_last) r_len <= w_word[ADDR_W:0];
        end else begin
`ifdef IMEM_LOADER_CSUM_EN
          r_csum <= r_csum ^ i_s_data;
`endif
          if (w_lane_last) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= ADDR_W'(BASE_WADDR) + r_words[ADDR_W-1:0];
            r_mem_wdata <= w_word;
            r_words     <= r_words + ONE;
          end
        end
      end
    end
  end

endmodule
